ccff_chain_loader: RTL and testbench

Configuration-chain loader for the fabric's routing and logic tiles. It drives the serial `ccff_head` input of a configuration flip-flop chain, such as the `mux_tree_tapbuf_size2_mem` chain inside a switch block. It sequences each load through a flush, a chain-integrity probe and a bitstream load. Bitstream words arrive on a valid/ready handshake, and the block signals when the loaded chain is valid or broken.

---
 rtl/ccff_chain_loader.sv | 149 ++++++++++++++
 tb/tb_ccff_chain_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - configuration-chain loader: flush, integrity probe, bitstream load
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 8,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              ccff_shift_en,
   output logic              busy,
   output logic              done,
   output logic              error
);
   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam int BW = $clog2(WORD_W + 1);
   localparam logic [CW-1:0] LEN     = CW'(CHAIN_LEN);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [BW-1:0] BIT_ONE = BW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_FLUSH, S_PROBE, S_LOAD, S_DONE, S_ERR
   } state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx, taken, taken_nx, cnt_inc, rem;
   logic [BW-1:0]     wbits, wbits_nx, usable;
   logic [WORD_W-1:0] wreg, wreg_nx;
   logic              ready_nx, head_nx, shift_nx, busy_nx, done_nx, error_nx;

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         taken         <= '0;
         wbits         <= '0;
         wreg          <= '0;
         cfg_ready     <= 1'b0;
         ccff_head     <= 1'b0;
         ccff_shift_en <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         taken         <= taken_nx;
         wbits         <= wbits_nx;
         wreg          <= wreg_nx;
         cfg_ready     <= ready_nx;
         ccff_head     <= head_nx;
         ccff_shift_en <= shift_nx;
         busy          <= busy_nx;
         done          <= done_nx;
         error         <= error_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      taken_nx = taken;
      wbits_nx = wbits;
      wreg_nx  = wreg;
      ready_nx = cfg_ready;
      head_nx  = ccff_head;
      shift_nx = ccff_shift_en;
      busy_nx  = busy;
      done_nx  = done;
      error_nx = error;
      cnt_inc  = cnt + CNT_ONE;
      // Bits of the next word that still fit in the chain; the rest are dropped.
      rem      = LEN - taken;
      usable   = (32'(rem) >= 32'(WORD_W)) ? BW'(WORD_W) : BW'(rem);

      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nx = S_FLUSH;
               cnt_nx   = '0;
               taken_nx = '0;
               wbits_nx = '0;
               ready_nx = 1'b0;
               head_nx  = 1'b0;
               shift_nx = 1'b1;
               busy_nx  = 1'b1;
               done_nx  = 1'b0;
               error_nx = 1'b0;
            end
         end
         S_FLUSH: begin
            cnt_nx = cnt_inc;
            if (cnt_inc == LEN) begin
               state_nx = S_PROBE;
               cnt_nx   = '0;
               head_nx  = 1'b1;
            end
         end
         S_PROBE: begin
            // cnt = probe shifts already taken; tail now reflects shift number cnt.
            head_nx = 1'b0;
            if (cnt != '0 && ccff_tail != (cnt == LEN)) begin
               state_nx = S_ERR;
               shift_nx = 1'b0;
               busy_nx  = 1'b0;
               error_nx = 1'b1;
            end else if (cnt == LEN) begin
               state_nx = S_LOAD;
               cnt_nx   = '0;
               ready_nx = 1'b1;
            end else begin
               cnt_nx   = cnt_inc;
               shift_nx = (cnt_inc != LEN);
            end
         end
         S_LOAD: begin
            if (cfg_valid && cfg_ready) begin
               ready_nx = 1'b0;
               shift_nx = 1'b1;
               head_nx  = cfg_data[WORD_W-1];
               wreg_nx  = cfg_data << 1;
               wbits_nx = usable - BIT_ONE;
               taken_nx = taken + CW'(usable);
            end else if (ccff_shift_en) begin
               cnt_nx = cnt_inc;
               if (cnt_inc == LEN) begin
                  state_nx = S_DONE;
                  shift_nx = 1'b0;
                  head_nx  = 1'b0;
                  busy_nx  = 1'b0;
                  done_nx  = 1'b1;
               end else if (wbits != '0) begin
                  head_nx  = wreg[WORD_W-1];
                  wreg_nx  = wreg << 1;
                  wbits_nx = wbits - BIT_ONE;
               end else begin
                  shift_nx = 1'b0;
                  ready_nx = 1'b1;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - scoreboard bench for ccff_chain_loader driving a behavioural chain
module tb_ccff_chain_loader;
   localparam int N   = 10;
   localparam int W   = 4;
   localparam int NW  = (N + W - 1) / W;
   localparam int TMO = 400;

   logic         prog_clk = 1'b0;
   logic         pReset   = 1'b0;
   logic         start    = 1'b0;
   logic         cfg_valid = 1'b0;
   logic [W-1:0] cfg_data = '0;
   logic         ccff_tail;
   logic         cfg_ready, ccff_head, ccff_shift_en, busy, done, error;

   ccff_chain_loader #(.CHAIN_LEN(N), .WORD_W(W)) dut (
      .prog_clk(prog_clk), .pReset(pReset), .start(start),
      .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .ccff_head(ccff_head), .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en),
      .busy(busy), .done(done), .error(error)
   );

   always #5 prog_clk = ~prog_clk;

   // Behavioural chain: chain[0] is the head flop, chain[clen-1] the tail.
   logic [15:0] chain = '0;
   int          clen  = N;
   bit          stuck = 1'b0;
   always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[14:0], ccff_head};
   assign ccff_tail = stuck ? 1'b0 : chain[clen-1];

   typedef struct {
      bit           is_err;
      logic [N-1:0] chain;
      int           lat;
      int           smin;
      int           smax;
      int           words;
   } exp_t;

   exp_t     exp_q[$];
   exp_t     cur;
   int       checks = 0;
   int       failures = 0;
   int       cyc = 0, shifts = 0, hs = 0;
   bit       ready_seen = 1'b0;
   logic     done_q = 1'b0, error_q = 1'b0;
   logic [1:0] prev_res = 2'b00;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: concatenate words MSB first, the first N bits end up tail..head.
   function automatic exp_t model_load(input logic [W-1:0] words[$], input int gaps[$]);
      bit   bits[$];
      exp_t e;
      foreach (words[i]) for (int b = W - 1; b >= 0; b--) bits.push_back(words[i][b]);
      e.is_err = 1'b0;
      e.chain  = '0;
      for (int i = 0; i < N; i++) e.chain[N-1-i] = bits[i];
      e.words = NW;
      e.lat   = 2 * N + 1 + NW + N;
      for (int i = 0; i < NW; i++) e.lat += gaps[i];
      e.smin  = 3 * N;
      e.smax  = 3 * N;
      return e;
   endfunction

   always @(posedge prog_clk) begin
      if (start && busy === 1'b0) begin
         cyc <= 0; shifts <= 0; hs <= 0; ready_seen <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (ccff_shift_en) shifts <= shifts + 1;
         if (cfg_valid && cfg_ready) hs <= hs + 1;
         if (cfg_ready) ready_seen <= 1'b1;
      end
   end

   always @(negedge prog_clk) begin
      if ((done && !done_q) || (error && !error_q)) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_completion done=%0b error=%0b required=none", done, error);
         end else begin
            cur = exp_q.pop_front();
            check("result_kind", {done, error}, cur.is_err ? 2'b01 : 2'b10);
            if (!cur.is_err) begin
               check("total_shifts", shifts, cur.smin);
               check("chain_contents", chain[N-1:0], cur.chain);
               check("handshakes", hs, cur.words);
               check("cycles_to_done", cyc, cur.lat);
            end else begin
               check("err_shift_range", (shifts >= cur.smin && shifts <= cur.smax), 1'b1);
               check("err_handshakes", hs, 0);
               check("err_ready_seen", ready_seen, 1'b0);
            end
         end
      end
      done_q  = done;
      error_q = error;
   end

   task automatic pulse_start();
      @(negedge prog_clk);
      check("held_result", {done, error}, prev_res);
      start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
      check("start_response", {busy, done, error, ccff_shift_en, ccff_head}, 5'b10010);
   endtask

   task automatic feed(input logic [W-1:0] words[$], input int gaps[$], input int busy_start_at);
      int wi = 0, g = 0, t = 0;
      bit hs_next = 1'b0, fin = 1'b0;
      while (!fin) begin
         @(negedge prog_clk);
         if (hs_next) begin wi++; g = 0; end
         if (done || error) begin
            fin = 1'b1;
         end else if (t > TMO) begin
            fin = 1'b1;
            checks++;
            failures++;
            $display("FAIL feed_timeout cycles=%0d required=completion", t);
         end else begin
            start = (t == busy_start_at);
            if (wi < words.size()) begin
               if (g < gaps[wi]) begin
                  cfg_valid = 1'b0;
                  if (cfg_ready) g++;
               end else begin
                  cfg_valid = 1'b1;
                  cfg_data  = words[wi];
               end
            end else begin
               cfg_valid = 1'b1;
               cfg_data  = W'($urandom);
            end
            hs_next = cfg_valid && cfg_ready;
         end
         t++;
      end
      cfg_valid = 1'b0;
      start     = 1'b0;
   endtask

   task automatic run_normal(input logic [W-1:0] words[$], input int gaps[$], input int busy_start_at);
      exp_q.push_back(model_load(words, gaps));
      pulse_start();
      feed(words, gaps, busy_start_at);
      prev_res = 2'b10;
   endtask

   task automatic run_error(input int smin, input int smax);
      exp_t         e;
      logic [W-1:0] none_w[$];
      int           none_g[$];
      e.is_err = 1'b1; e.chain = '0; e.lat = 0; e.smin = smin; e.smax = smax; e.words = 0;
      exp_q.push_back(e);
      pulse_start();
      feed(none_w, none_g, -1);
      prev_res = 2'b01;
   endtask

   task automatic random_words(output logic [W-1:0] wq[$], output int gq[$]);
      wq.delete();
      gq.delete();
      for (int i = 0; i < NW; i++) begin
         wq.push_back(W'($urandom));
         gq.push_back(int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] wq[$];
      int           gq[$];
      bit           saw;

      #2 pReset = 1'b1;
      #1 check("reset_async_outputs", {cfg_ready, ccff_head, ccff_shift_en, busy, done, error}, 6'b0);
      repeat (3) @(negedge prog_clk);
      pReset = 1'b0;
      saw = 1'b0;
      repeat (10) begin
         @(negedge prog_clk);
         if (ccff_shift_en || busy) saw = 1'b1;
      end
      check("idle_no_shift", saw, 1'b0);

      wq = '{W'('hF), W'('h0), W'('hC)};
      gq = '{0, 0, 0};
      run_normal(wq, gq, -1);
      gq = '{5, 0, 0};
      run_normal(wq, gq, -1);

      for (int r = 0; r < 6; r++) begin
         random_words(wq, gq);
         run_normal(wq, gq, (r == 2) ? 20 : -1);
      end

      stuck = 1'b1;
      run_error(2 * N, 2 * N);
      stuck = 1'b0;
      random_words(wq, gq);
      run_normal(wq, gq, -1);

      clen = N - 1;
      run_error(2 * N - 1, 2 * N);
      clen = N;

      // Abort a load partway through its first word, then reload cleanly.
      pulse_start();
      for (int t = 0; t < TMO && !cfg_ready; t++) @(negedge prog_clk);
      check("load_ready_reached", cfg_ready, 1'b1);
      cfg_valid = 1'b1;
      cfg_data  = W'($urandom);
      @(negedge prog_clk);
      cfg_valid = 1'b0;
      @(negedge prog_clk);
      check("mid_load_shifting", {busy, ccff_shift_en}, 2'b11);
      #2 pReset = 1'b1;
      #1 check("abort_async_outputs", {cfg_ready, ccff_head, ccff_shift_en, busy, done, error}, 6'b0);
      @(negedge prog_clk);
      pReset   = 1'b0;
      prev_res = 2'b00;
      random_words(wq, gq);
      run_normal(wq, gq, -1);

      repeat (3) @(negedge prog_clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
